cart_mapper: RTL and testbench

Memory-side mapper between the CPU core and the cartridge/boot storage. It decodes CPU bus accesses to 0x0000–0x7FFF, 0xA000–0xBFFF and 0xFF50, and applies the DMG boot-ROM overlay over 0x0000–0x00FF until software disables it. It implements MBC1 ROM/RAM banking and returns read data one cycle after the request, matching the synchronous ROM/RAM macros.

---
 rtl/gb_pkg.sv | 35 +++
 rtl/cart_mapper_if.sv | 20 ++
 rtl/mbc1_regs.sv | 66 ++++++
 rtl/cart_mapper.sv | 109 ++++++++++
 tb/tb_cart_mapper.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_pkg.sv
// Shared cartridge-bus definitions: region bases, read-source select, decode helpers.
package gb_pkg;

  localparam logic [15:0] ROM0     = 16'h0000;
  localparam logic [15:0] ROMX     = 16'h4000;
  localparam logic [15:0] CRAM     = 16'hA000;
  localparam logic [15:0] BOOT_OFF = 16'hFF50;

  localparam int unsigned BANK_W = 7;
  localparam int unsigned LO_W   = 5;
  localparam int unsigned HI_W   = 2;

  typedef enum logic [1:0] {SRC_BOOT, SRC_ROM, SRC_RAM, SRC_FF} rd_src_e;

  // 0x0000-0x7FFF
  function automatic logic is_rom(input logic [15:0] a);
    return a[15] == ROM0[15];
  endfunction

  // 0x4000-0x7FFF (switchable bank window)
  function automatic logic is_romx(input logic [15:0] a);
    return a[15:14] == ROMX[15:14];
  endfunction

  // 0xA000-0xBFFF
  function automatic logic is_cram(input logic [15:0] a);
    return a[15:13] == CRAM[15:13];
  endfunction

  // 0x0000-0x00FF, the region covered by the boot overlay
  function automatic logic is_boot(input logic [15:0] a);
    return a[15:8] == 8'h00;
  endfunction

endpackage

// File: rtl/cart_mapper_if.sv
// CPU-side byte bus into the cartridge mapper.
interface cart_mapper_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_hit;

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  cpu_rdata, cpu_rvalid, cpu_hit
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output cpu_rdata, cpu_rvalid, cpu_hit
  );
endinterface

// File: rtl/mbc1_regs.sv
// MBC1 control registers and the effective ROM/RAM bank numbers derived from them.
module mbc1_regs
  import gb_pkg::*;
#(
  parameter int unsigned MBC_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [2:0]        sel_i,
  input  logic [LO_W-1:0]   wdata_i,
  output logic              ram_en_c_o,
  output logic [BANK_W-1:0] rom0_bank_c_o,
  output logic [BANK_W-1:0] romx_bank_c_o,
  output logic [HI_W-1:0]   ram_bank_c_o
);

  localparam bit MBC_ON = (MBC_EN != 0);

  logic            ram_en_q, ram_en_d;
  logic [LO_W-1:0] bank_lo_q, bank_lo_d;
  logic [HI_W-1:0] bank_hi_q, bank_hi_d;
  logic            mode_q, mode_d;
  logic [LO_W-1:0] eff_lo;

  // Register writes land in the 0x0000-0x7FFF window, one register per 8 KB slice
  always_comb begin
    ram_en_d  = ram_en_q;
    bank_lo_d = bank_lo_q;
    bank_hi_d = bank_hi_q;
    mode_d    = mode_q;
    if (MBC_ON && wr_i && !sel_i[2]) begin
      unique case (sel_i[1:0])
        2'b00: ram_en_d  = (wdata_i[3:0] == 4'hA);
        2'b01: bank_lo_d = wdata_i;
        2'b10: bank_hi_d = wdata_i[HI_W-1:0];
        2'b11: mode_d    = wdata_i[0];
      endcase
    end
  end

  // Register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en_q  <= 1'b0;
      bank_lo_q <= '0;
      bank_hi_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      ram_en_q  <= ram_en_d;
      bank_lo_q <= bank_lo_d;
      bank_hi_q <= bank_hi_d;
      mode_q    <= mode_d;
    end
  end

  // Only the all-zero low bank is remapped; a disabled mapper is a flat 32 KB cart
  always_comb begin
    eff_lo        = (bank_lo_q == '0) ? LO_W'(1) : bank_lo_q;
    ram_en_c_o    = MBC_ON ? ram_en_q : 1'b1;
    rom0_bank_c_o = (MBC_ON && mode_q) ? {bank_hi_q, LO_W'(0)} : '0;
    romx_bank_c_o = MBC_ON ? {bank_hi_q, eff_lo} : BANK_W'(1);
    ram_bank_c_o  = (MBC_ON && mode_q) ? bank_hi_q : '0;
  end

endmodule

// File: rtl/cart_mapper.sv
// Cartridge/boot-ROM mapper: address decode, boot overlay and 1-cycle read pipeline.
module cart_mapper
  import gb_pkg::*;
#(
  parameter int unsigned ROM_ADDR_W = 21,
  parameter int unsigned RAM_ADDR_W = 15,
  parameter int unsigned MBC_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cart_mapper_if.slave          bus,
  output logic [7:0]            boot_addr,
  input  logic [7:0]            boot_data,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic [7:0]            ram_data,
  output logic                  boot_en
);

  logic              ram_en;
  logic [BANK_W-1:0] rom0_bank, romx_bank;
  logic [HI_W-1:0]   ram_bank;

  logic    boot_en_q;
  rd_src_e src_q, src_d;
  logic    hit_q, hit_d;
  logic    rvalid_q;
  logic [7:0] hold_q, rdata_mux;
  logic    rd_acc, boot_clr;

  mbc1_regs #(.MBC_EN(MBC_EN)) u_regs (
    .clk           (clk),
    .rst           (rst),
    .wr_i          (bus.cpu_wr),
    .sel_i         (bus.cpu_addr[15:13]),
    .wdata_i       (bus.cpu_wdata[LO_W-1:0]),
    .ram_en_c_o    (ram_en),
    .rom0_bank_c_o (rom0_bank),
    .romx_bank_c_o (romx_bank),
    .ram_bank_c_o  (ram_bank)
  );

  // A simultaneous write wins; the read is dropped
  assign rd_acc   = bus.cpu_rd && !bus.cpu_wr;
  assign boot_clr = bus.cpu_wr && (bus.cpu_addr == BOOT_OFF) && (bus.cpu_wdata != 8'h00);

  // Memory-side addresses and RAM strobe track the CPU bus with no latency
  assign boot_addr = bus.cpu_addr[7:0];
  assign rom_addr  = ROM_ADDR_W'({(is_romx(bus.cpu_addr) ? romx_bank : rom0_bank),
                                  bus.cpu_addr[13:0]});
  assign ram_addr  = RAM_ADDR_W'({ram_bank, bus.cpu_addr[12:0]});
  assign ram_wdata = bus.cpu_wdata;
  assign ram_we    = bus.cpu_wr && is_cram(bus.cpu_addr) && ram_en;
  assign boot_en   = boot_en_q;

  // Read source priority: overlay, ROM, enabled RAM, then open bus
  always_comb begin
    src_d = SRC_FF;
    hit_d = 1'b0;
    if (boot_en_q && is_boot(bus.cpu_addr)) begin
      src_d = SRC_BOOT;
      hit_d = 1'b1;
    end else if (is_rom(bus.cpu_addr)) begin
      src_d = SRC_ROM;
      hit_d = 1'b1;
    end else if (is_cram(bus.cpu_addr)) begin
      src_d = ram_en ? SRC_RAM : SRC_FF;
      hit_d = 1'b1;
    end
  end

  // Select the memory data that the registered source points at
  always_comb begin
    rdata_mux = 8'hFF;
    unique case (src_q)
      SRC_BOOT: rdata_mux = boot_data;
      SRC_ROM:  rdata_mux = rom_data;
      SRC_RAM:  rdata_mux = ram_data;
      SRC_FF:   rdata_mux = 8'hFF;
    endcase
  end

  // Read pipeline, data hold and sticky overlay flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= SRC_FF;
      hit_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      hold_q    <= 8'hFF;
      boot_en_q <= 1'b1;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        src_q <= src_d;
        hit_q <= hit_d;
      end
      if (rvalid_q) hold_q <= rdata_mux;
      if (boot_clr) boot_en_q <= 1'b0;
    end
  end

  assign bus.cpu_rdata  = rvalid_q ? rdata_mux : hold_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_hit    = hit_q;

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper with behavioural boot/ROM/RAM macros.
module tb_cart_mapper;

  logic        clk;
  logic        rst_n;
  logic [7:0]  boot_addr, boot_data;
  logic [20:0] rom_addr;
  logic [7:0]  rom_data;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata, ram_data;
  logic        ram_we;
  logic        boot_en;
  logic [7:0]  ram_mem [0:32767];

  int checks = 0;
  int errors = 0;

  cart_mapper_if bus();

  cart_mapper #(.ROM_ADDR_W(21), .RAM_ADDR_W(15), .MBC_EN(1)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .boot_addr (boot_addr),
    .boot_data (boot_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_data  (ram_data),
    .boot_en   (boot_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] boot_fn(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rom_fn(input logic [20:0] a);
    return a[7:0] ^ {1'b0, a[20:14]};
  endfunction

  // Synchronous macros: data one cycle after address
  always @(posedge clk) begin
    boot_data <= boot_fn(boot_addr);
    rom_data  <= rom_fn(rom_addr);
    ram_data  <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  task automatic do_read(input logic [15:0] a, output logic [20:0] ra, output logic [14:0] rma,
                         output logic [7:0] d, output logic v, output logic h);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    #1;
    ra  = rom_addr;
    rma = ram_addr;
    @(posedge clk);
    #1;
    bus.cpu_rd = 1'b0;
    d = bus.cpu_rdata;
    v = bus.cpu_rvalid;
    h = bus.cpu_hit;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] wd,
                          output logic we, output logic [14:0] rma);
    @(negedge clk);
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    bus.cpu_wr    = 1'b1;
    #1;
    we  = ram_we;
    rma = ram_addr;
    @(posedge clk);
    #1;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", bus.cpu_rvalid); end
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bus.cpu_hit); end
    checks++; if (bus.cpu_rdata !== 8'hFF) begin errors++; $display("FAIL reset_rdata got %h exp ff", bus.cpu_rdata); end
    checks++; if (boot_en !== 1'b1) begin errors++; $display("FAIL reset_boot_en got %b exp 1", boot_en); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    logic [20:0] ra; logic [14:0] rma; logic [7:0] d; logic v, h, we;
    do_read(16'h0000, ra, rma, d, v, h);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL boot_rdata got %h exp a5", d); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL boot_rvalid got %b exp 1", v); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL boot_hit got %b exp 1", h); end
    // Move the address so the boot macro output changes; rdata must hold
    bus.cpu_addr = 16'h0055;
    @(posedge clk); #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b exp 0", bus.cpu_rvalid); end
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rdata_hold got %h exp a5", bus.cpu_rdata); end
    do_write(16'hFF50, 8'h01, we, rma);
    checks++; if (boot_en !== 1'b0) begin errors++; $display("FAIL boot_disable got %b exp 0", boot_en); end
    do_read(16'h0000, ra, rma, d, v, h);
    checks++; if (ra !== 21'h000000) begin errors++; $display("FAIL rom0_addr got %h exp 000000", ra); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rom0_rdata got %h exp 00", d); end
  endtask

  task automatic test_banking();
    logic [20:0] ra; logic [14:0] rma; logic [7:0] d; logic v, h, we;
    do_write(16'h2000, 8'h00, we, rma);
    do_read(16'h4123, ra, rma, d, v, h);
    checks++; if (ra !== 21'h004123) begin errors++; $display("FAIL bank0_remap_addr got %h exp 004123", ra); end
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL bank0_remap_rdata got %h exp 22", d); end
    do_write(16'h2000, 8'h05, we, rma);
    do_read(16'h4123, ra, rma, d, v, h);
    checks++; if (ra !== 21'h014123) begin errors++; $display("FAIL bank5_addr got %h exp 014123", ra); end
    checks++; if (d !== 8'h26) begin errors++; $display("FAIL bank5_rdata got %h exp 26", d); end
    do_write(16'h4000, 8'h02, we, rma);
    do_read(16'h7FFF, ra, rma, d, v, h);
    checks++; if (ra !== 21'h117FFF) begin errors++; $display("FAIL bank_hi_addr got %h exp 117fff", ra); end
    checks++; if (d !== 8'hBA) begin errors++; $display("FAIL bank_hi_rdata got %h exp ba", d); end
    do_write(16'h6000, 8'h01, we, rma);
    do_read(16'h0010, ra, rma, d, v, h);
    checks++; if (ra !== 21'h100010) begin errors++; $display("FAIL mode1_rom0_addr got %h exp 100010", ra); end
    checks++; if (d !== 8'h50) begin errors++; $display("FAIL mode1_rom0_rdata got %h exp 50", d); end
  endtask

  task automatic test_ram();
    logic [20:0] ra; logic [14:0] rma; logic [7:0] d; logic v, h, we;
    do_read(16'hA000, ra, rma, d, v, h);
    checks++; if (d !== 8'hFF || h !== 1'b1) begin errors++; $display("FAIL ram_off_read got %h/%b exp ff/1", d, h); end
    do_write(16'hA000, 8'h5A, we, rma);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL ram_off_we got %b exp 0", we); end
    do_write(16'h0000, 8'h0A, we, rma);
    do_write(16'hA000, 8'h5A, we, rma);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL ram_on_we got %b exp 1", we); end
    checks++; if (rma !== 15'h4000) begin errors++; $display("FAIL ram_bank2_addr got %h exp 4000", rma); end
    do_read(16'hA000, ra, rma, d, v, h);
    checks++; if (d !== 8'h5A || h !== 1'b1) begin errors++; $display("FAIL ram_readback got %h/%b exp 5a/1", d, h); end
    do_write(16'h6000, 8'h00, we, rma);
    do_write(16'hA010, 8'h3C, we, rma);
    checks++; if (rma !== 15'h0010 || we !== 1'b1) begin errors++; $display("FAIL ram_mode0_write got %h/%b exp 0010/1", rma, we); end
    do_read(16'hA010, ra, rma, d, v, h);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL ram_mode0_read got %h exp 3c", d); end
    do_read(16'hC000, ra, rma, d, v, h);
    checks++; if (d !== 8'hFF || h !== 1'b0 || v !== 1'b1) begin errors++; $display("FAIL unmapped_read got %h/%b/%b exp ff/0/1", d, h, v); end
    do_read(16'hFF50, ra, rma, d, v, h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL ff50_read_hit got %b exp 0", h); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_d = 8'(i - 1) ^ 8'h45;
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp_d) begin errors++; $display("FAIL b2b_read%0d got %h/%b exp %h/1", i - 1, bus.cpu_rdata, bus.cpu_rvalid, exp_d); end
      end
      bus.cpu_addr = 16'h4000 + 16'(i);
      bus.cpu_rd   = 1'b1;
    end
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h46) begin errors++; $display("FAIL b2b_read3 got %h/%b exp 46/1", bus.cpu_rdata, bus.cpu_rvalid); end
  endtask

  task automatic test_rd_wr_collision();
    logic [20:0] ra; logic [14:0] rma; logic [7:0] d; logic v, h;
    @(negedge clk);
    bus.cpu_addr = 16'h2000; bus.cpu_wdata = 8'h03; bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rdwr_rvalid got %b exp 0", bus.cpu_rvalid); end
    do_read(16'h4000, ra, rma, d, v, h);
    checks++; if (ra !== 21'h10C000 || d !== 8'h43) begin errors++; $display("FAIL rdwr_bank3 got %h/%h exp 10c000/43", ra, d); end
  endtask

  task automatic test_reset_mid_read();
    logic [20:0] ra; logic [14:0] rma; logic [7:0] d; logic v, h;
    @(negedge clk);
    bus.cpu_addr = 16'h4001; bus.cpu_rd = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b exp 0", bus.cpu_rvalid); end
    checks++; if (bus.cpu_rdata !== 8'hFF || boot_en !== 1'b1) begin errors++; $display("FAIL midrst_state got %h/%b exp ff/1", bus.cpu_rdata, boot_en); end
    @(negedge clk);
    rst_n = 1'b1;
    do_read(16'h4000, ra, rma, d, v, h);
    checks++; if (ra !== 21'h004000) begin errors++; $display("FAIL post_rst_bank got %h exp 004000", ra); end
    do_read(16'h0000, ra, rma, d, v, h);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL post_rst_boot got %h exp a5", d); end
    do_read(16'hA000, ra, rma, d, v, h);
    checks++; if (d !== 8'hFF || h !== 1'b1 || rma !== 15'h0000) begin errors++; $display("FAIL post_rst_ram got %h/%b/%h exp ff/1/0000", d, h, rma); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_banking();
    test_ram();
    test_back_to_back();
    test_rd_wr_collision();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
